rf_mem_port_ctrl: RTL and testbench

- Request-side controller that sits directly upstream of the byte-enabled 1RW register-file RAM.
- Turns byte-addressed load/store requests (byte/half/word, signed or unsigned) into RAM word accesses with lane-aligned data and byte enables.
- Splits accesses that cross a word boundary into two RAM accesses.
- Returns load data aligned and extended, or a store ack, through a valid/ready response channel.

---
 rtl/rf_mem_port_ctrl_if.sv | 31 +++
 rtl/rf_mem_port_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rf_mem_port_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_mem_port_ctrl_if.sv
// Request/response channel between a load/store client and rf_mem_port_ctrl.
// The master side issues requests and consumes responses; the controller is the slave.
interface rf_mem_port_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(DEPTH) + 2;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [1:0]       req_size;
    logic             req_signed;
    logic [WIDTH-1:0] req_wdata;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_signed, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rf_mem_port_ctrl.sv
// Load/store front end for a byte-enabled 1RW register-file RAM: aligns byte lanes,
// splits word-crossing accesses in two, and returns extended load data or a store ack.
module rf_mem_port_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     eph1,
    input  logic                     resetn,
    rf_mem_port_ctrl_if.slave        bus,
    output logic                     ram_write,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic [3:0]               ram_wben,
    output logic [WIDTH-1:0]         ram_din,
    input  logic [WIDTH-1:0]         ram_dout
);
    localparam int            AW        = $clog2(DEPTH) + 2;
    localparam int            WW        = $clog2(DEPTH);
    localparam logic [WW-1:0] LAST_WORD = WW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, DRAIN, RESP} state_e;

    state_e           state_q, state_d;
    logic             write_q, signed_q, split_q;
    logic [1:0]       size_q, off_q;
    logic [WW-1:0]    word_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] word0_q, word0_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Decode of the incoming request, only meaningful while IDLE
    logic [1:0]    in_off;
    logic [WW-1:0] in_word;
    logic          in_split, in_err, accept;

    assign in_off   = bus.req_addr[1:0];
    assign in_word  = bus.req_addr[AW-1:2];
    assign in_split = ({1'b0, in_off} + size_bytes(bus.req_size)) > 3'd4;
    assign in_err   = (bus.req_size == 2'd3) || (in_split && (in_word == LAST_WORD));
    assign accept   = bus.req_valid && (state_q == IDLE);

    // Store path: keep only the requested bytes, then rotate them onto their lanes
    logic [3:0]       mask;
    logic [7:0]       lane_en;
    logic [5:0]       shamt;
    logic [WIDTH-1:0] wdata_masked, store_din;

    assign mask      = size_mask(size_q);
    assign lane_en   = {4'b0000, mask} << off_q;
    assign shamt     = {1'b0, off_q, 3'b000};
    assign store_din = (wdata_masked << shamt) | (wdata_masked >> (6'd32 - shamt));

    always_comb begin
        wdata_masked = '0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) wdata_masked[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Load path: lanes at or above the offset come from the first word, the rest from the second
    logic [WIDTH-1:0] lo_word, merged, aligned, load_result;

    assign lo_word = split_q ? word0_q : ram_dout;
    assign aligned = (merged >> shamt) | (merged << (6'd32 - shamt));

    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = (i >= int'(off_q)) ? lo_word[8*i +: 8] : ram_dout[8*i +: 8];
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    load_result = {{24{signed_q & aligned[7]}}, aligned[7:0]};
            2'd1:    load_result = {{16{signed_q & aligned[15]}}, aligned[15:0]};
            default: load_result = aligned;
        endcase
    end

    // NOTE: every output and next-state variable gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        word0_d       = word0_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        bus.req_ready = 1'b0;
        ram_write     = 1'b0;
        ram_addr      = '0;
        ram_wben      = '0;
        ram_din       = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = in_err ? RESP : ACC0;
                    err_d   = in_err;
                    rdata_d = '0;
                end
            end
            ACC0: begin
                ram_addr = word_q;
                if (write_q) begin
                    ram_write = 1'b1;
                    ram_wben  = lane_en[3:0];
                    ram_din   = store_din;
                end
                if (split_q)      state_d = ACC1;
                else if (write_q) state_d = RESP;
                else              state_d = DRAIN;
            end
            ACC1: begin
                ram_addr = word_q + WW'(1);
                if (write_q) begin
                    ram_write = 1'b1;
                    ram_wben  = lane_en[7:4];
                    ram_din   = store_din;
                    state_d   = RESP;
                end else begin
                    word0_d = ram_dout;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rdata_d = load_result;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge eph1 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            word0_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            split_q  <= 1'b0;
            size_q   <= 2'd0;
            off_q    <= 2'd0;
            word_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            word0_q <= word0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q  <= bus.req_write;
                signed_q <= bus.req_signed;
                split_q  <= in_split;
                size_q   <= bus.req_size;
                off_q    <= in_off;
                word_q   <= in_word;
                wdata_q  <= bus.req_wdata;
            end
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_rf_mem_port_ctrl.sv
// Bench for rf_mem_port_ctrl: directed scenarios plus random traffic checked against
// a flat byte-array model of memory, with a registered-address RAM behind the DUT.
module tb_rf_mem_port_ctrl;
    localparam int DEPTH  = 8;
    localparam int WIDTH  = 32;
    localparam int AW     = $clog2(DEPTH) + 2;
    localparam int WW     = $clog2(DEPTH);
    localparam int NBYTES = DEPTH * 4;

    logic             eph1   = 1'b0;
    logic             resetn = 1'b1;
    logic             ram_write;
    logic [WW-1:0]    ram_addr;
    logic [3:0]       ram_wben;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_dout;

    rf_mem_port_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    rf_mem_port_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .eph1     (eph1),
        .resetn   (resetn),
        .bus      (bus),
        .ram_write(ram_write),
        .ram_addr (ram_addr),
        .ram_wben (ram_wben),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 eph1 = ~eph1;

    // RAM with address registered on the clock edge
    logic [31:0]   ram_mem [DEPTH];
    logic [WW-1:0] ram_addr_q;
    always @(posedge eph1) begin
        if (ram_write) begin
            for (int i = 0; i < 4; i++)
                if (ram_wben[i]) ram_mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
        end
        ram_addr_q <= ram_addr;
    end
    assign ram_dout = ram_mem[ram_addr_q];

    typedef struct packed {
        logic [WW-1:0] addr;
        logic [3:0]    wben;
        logic [31:0]   din;
    } wr_t;
    wr_t wlog[$];
    always @(negedge eph1) if (ram_write === 1'b1) wlog.push_back({ram_addr, ram_wben, ram_din});

    logic [7:0] ref_bytes [NBYTES];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    function automatic wr_t get_wr(input int idx);
        if (idx < wlog.size()) return wlog[idx];
        return '0;
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    function automatic logic [31:0] model_load(input int addr, input int n, input bit sgn);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_bytes[addr + k];
        if (sgn && n < 4 && v[8*n-1]) begin
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    // Issue one request starting at a falling edge; returns at the falling edge after the handshake.
    task automatic do_req(input string tag, input bit w, input int addr, input int size,
                          input bit sgn, input logic [31:0] wdata, input int hold);
        int n, lat, guard, exp_lat, exp_wr;
        bit exp_err, split;
        logic [31:0] exp_rd;
        n       = (size == 3) ? 4 : (1 << size);
        split   = ((addr % 4) + n) > 4;
        exp_err = (size == 3) || (addr + n > NBYTES);
        exp_rd  = (exp_err || w) ? 32'h0 : model_load(addr, n, sgn);
        exp_lat = exp_err ? 1 : ((w ? 2 : 3) + (split ? 1 : 0));
        exp_wr  = (exp_err || !w) ? 0 : (split ? 2 : 1);
        wlog.delete();

        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_addr   = AW'(addr);
        bus.req_size   = 2'(size);
        bus.req_signed = sgn;
        bus.req_wdata  = wdata;
        #1;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(negedge eph1); #1; guard++;
        end
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge eph1); #1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_addr   = AW'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_wdata  = $urandom;
        if (w && !exp_err) begin
            for (int k = 0; k < n; k++) ref_bytes[addr + k] = wdata[8*k +: 8];
        end

        lat = 1;
        @(negedge eph1);
        while (bus.rsp_valid !== 1'b1 && lat < 12) begin
            @(negedge eph1); lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "/rsp_rdata"}, bus.rsp_rdata, exp_rd);
        check({tag, "/ram_writes"}, 32'(wlog.size()), 32'(exp_wr));
        for (int h = 0; h < hold; h++) begin
            @(negedge eph1);
            check({tag, "/hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "/hold_rdata"}, bus.rsp_rdata, exp_rd);
            check({tag, "/hold_err"}, 32'(bus.rsp_err), 32'(exp_err));
            check({tag, "/hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge eph1);
        @(negedge eph1);
        bus.rsp_ready = 1'b0;
        check({tag, "/rsp_valid_after_hs"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "/req_ready_after_hs"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t e;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        for (int wd = 0; wd < DEPTH; wd++) begin
            ram_mem[wd] = $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4*wd + b] = ram_mem[wd][8*b +: 8];
        end

        // Asynchronous reset, observed before the first clock edge
        #1 resetn = 1'b0;
        #2;
        check("reset/req_ready", 32'(bus.req_ready), 32'd1);
        check("reset/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset/rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset/rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset/ram_write", 32'(ram_write), 32'd0);
        check("reset/ram_wben", 32'(ram_wben), 32'd0);
        check("reset/ram_addr", 32'(ram_addr), 32'd0);
        check("reset/ram_din", ram_din, 32'd0);
        repeat (2) @(negedge eph1);
        resetn = 1'b1;

        do_req("word_store", 1'b1, 'h04, 2, 1'b0, 32'hDEADBEEF, 0);
        e = get_wr(0);
        check("word_store/addr", 32'(e.addr), 32'd1);
        check("word_store/wben", 32'(e.wben), 32'hF);
        check("word_store/din", e.din, 32'hDEADBEEF);

        do_req("byte_store", 1'b1, 'h0A, 0, 1'b0, 32'h000000A5, 0);
        e = get_wr(0);
        check("byte_store/addr", 32'(e.addr), 32'd2);
        check("byte_store/wben", 32'(e.wben), 32'b0100);
        check("byte_store/din_lane2", 32'(e.din[23:16]), 32'hA5);
        do_req("byte_load_s", 1'b0, 'h0A, 0, 1'b1, 32'h0, 0);
        do_req("byte_load_u", 1'b0, 'h0A, 0, 1'b0, 32'h0, 0);

        do_req("split_store", 1'b1, 'h07, 1, 1'b0, 32'h0000BEEF, 0);
        e = get_wr(0);
        check("split_store/acc0_addr", 32'(e.addr), 32'd1);
        check("split_store/acc0_wben", 32'(e.wben), 32'b1000);
        check("split_store/acc0_din_hi", 32'(e.din[31:24]), 32'hEF);
        e = get_wr(1);
        check("split_store/acc1_addr", 32'(e.addr), 32'd2);
        check("split_store/acc1_wben", 32'(e.wben), 32'b0001);
        check("split_store/acc1_din_lo", 32'(e.din[7:0]), 32'hBE);
        do_req("split_load", 1'b0, 'h07, 1, 1'b0, 32'h0, 0);
        check("split_load/model", model_load('h07, 2, 1'b0), 32'h0000BEEF);

        do_req("err_size3", 1'b1, 'h08, 3, 1'b0, 32'h11223344, 0);
        do_req("err_last_word", 1'b1, 'h1E, 2, 1'b0, 32'h55667788, 0);
        do_req("backpressure", 1'b0, 'h04, 2, 1'b0, 32'h0, 5);

        // Reset while a store is in its first RAM access
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = AW'('h10);
        bus.req_size  = 2'd2; bus.req_signed = 1'b0; bus.req_wdata = 32'h12345678;
        #1 check("rst_mid/req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge eph1); #1 bus.req_valid = 1'b0;
        @(negedge eph1);
        check("rst_mid/acc0_write", 32'(ram_write), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("rst_mid/ram_write", 32'(ram_write), 32'd0);
        check("rst_mid/ram_wben", 32'(ram_wben), 32'd0);
        check("rst_mid/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid/req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge eph1);
        @(negedge eph1);
        check("rst_mid/ram_unchanged", ram_mem[4], model_word(4));
        resetn = 1'b1;
        do_req("after_reset", 1'b0, 'h10, 2, 1'b0, 32'h0, 0);

        // Random traffic against the byte model
        for (int i = 0; i < 150; i++) begin
            int sz;
            sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            do_req($sformatf("rnd%0d", i), 1'($urandom), int'($urandom_range(0, NBYTES - 1)),
                   sz, 1'($urandom), $urandom, int'($urandom_range(0, 2)));
        end

        for (int wd = 0; wd < DEPTH; wd++)
            check($sformatf("final_ram%0d", wd), ram_mem[wd], model_word(wd));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
